// File: rtl/io_bus_pkg.sv
// Shared constants for the I/O bus responder: register offsets and interrupt bit positions.
// Pure declarations, no logic, no latency.
// No flow control; consumed by the responder top and its FIFO.
package io_bus_pkg;

    // Register offsets inside the 16-byte window
    localparam logic [3:0] OFS_OUT    = 4'd0;
    localparam logic [3:0] OFS_IN     = 4'd1;
    localparam logic [3:0] OFS_STATUS = 4'd2;
    localparam logic [3:0] OFS_RELOAD = 4'd3;
    localparam logic [3:0] OFS_MASK   = 4'd4;
    localparam logic [3:0] OFS_ACK    = 4'd5;

    // Interrupt / pending bit positions
    localparam int IRQ_TIMER = 0;
    localparam int IRQ_FIFO  = 1;
    localparam int IRQ_OVF   = 2;

    // STATUS only has a 3-bit count field; larger occupancies read as 7
    function automatic logic [2:0] sat_count3(input int unsigned c);
        return (c > 32'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO holding external input bytes; head is visible combinationally.
// Latency: a pushed entry is readable at the head one cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the push needs, so push+pop at full both succeed
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: output port, input-byte FIFO, reload timer and masked interrupts.
// Latency: reads are combinational in the bus cycle; writes and pops commit at the closing edge.
// Backpressure: dato_ext_ready drops when the FIFO is full; a byte offered while full with no pop is dropped and flagged.
module io_bus_responder
    import io_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 4,
    parameter int          PRESCALE   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_whisbone,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] dir,
    input  logic [7:0]  salidaDispositivo,
    output logic [7:0]  entradaDispositivo,
    output logic [2:0]  interrupciones,
    output logic [7:0]  puerto_salida,
    input  logic [7:0]  dato_ext,
    input  logic        dato_ext_valid,
    output logic        dato_ext_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic          sel, rd_en, wr_en;
    logic [3:0]    offset;
    logic [7:0]    out_q, out_d;
    logic [7:0]    reload_q, reload_d;
    logic [2:0]    mask_q, mask_d;
    logic [7:0]    counter_q, counter_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          pend_tmr_q, pend_tmr_d;
    logic          pend_ovf_q, pend_ovf_d;
    logic [2:0]    pend;
    logic          tick, fire;
    logic          pop_req, pop_ok, overflow;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [7:0]    status;
    logic [7:0]    rd_data;

    // Bus decode; a simultaneous rd+wr is treated as a write only
    assign sel     = enable_whisbone & (dir[15:4] == BASE_ADDR[15:4]);
    assign offset  = dir[3:0];
    assign wr_en   = sel & wr;
    assign rd_en   = sel & rd & ~wr;
    assign pop_req = rd_en & (offset == OFS_IN);
    assign pop_ok  = pop_req & ~fifo_empty;

    // A byte is lost only when the FIFO is full and no pop makes room this cycle
    assign overflow = dato_ext_valid & fifo_full & ~pop_ok;

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (dato_ext_valid),
        .pop_i   (pop_req),
        .data_i  (dato_ext),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Pending vector: timer and overflow are sticky, FIFO bit is a live level
    always_comb begin
        pend            = '0;
        pend[IRQ_TIMER] = pend_tmr_q;
        pend[IRQ_FIFO]  = ~fifo_empty;
        pend[IRQ_OVF]   = pend_ovf_q;
    end

    assign status = {pend, fifo_full, fifo_empty, sat_count3(32'(fifo_count))};

    // Read-data mux, valid only during a selected read
    always_comb begin
        rd_data = 8'h00;
        if (rd_en) begin
            case (offset)
                OFS_OUT:    rd_data = out_q;
                OFS_IN:     rd_data = fifo_empty ? 8'h00 : fifo_head;
                OFS_STATUS: rd_data = status;
                OFS_RELOAD: rd_data = reload_q;
                OFS_MASK:   rd_data = {5'b0, mask_q};
                default:    rd_data = 8'h00;
            endcase
        end
    end

    // Outputs forced quiet while reset is held, even before the first reset edge
    assign entradaDispositivo = reset ? 8'h00 : rd_data;
    assign puerto_salida      = reset ? 8'h00 : out_q;
    assign interrupciones     = reset ? 3'b000 : (pend & mask_q);
    assign dato_ext_ready     = ~reset & ~fifo_full;

    // Timer: prescaler produces a tick every PRESCALE cycles; counter reloads on expiry
    always_comb begin
        tick      = (reload_q != 8'h00) && (presc_q == PW'(PRESCALE - 1));
        fire      = tick && (counter_q == 8'd1);
        presc_d   = presc_q;
        counter_d = counter_q;
        if (reload_q != 8'h00) begin
            presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            counter_d = fire ? reload_q : counter_q - 8'd1;
        end
        if (wr_en && (offset == OFS_RELOAD) && (salidaDispositivo != 8'h00)) begin
            counter_d = salidaDispositivo;
            presc_d   = '0;
        end
    end

    // Register-file writes and sticky pending bits; a new event beats a same-cycle acknowledge
    always_comb begin
        out_d      = out_q;
        reload_d   = reload_q;
        mask_d     = mask_q;
        pend_tmr_d = pend_tmr_q;
        pend_ovf_d = pend_ovf_q;
        if (wr_en) begin
            case (offset)
                OFS_OUT:    out_d    = salidaDispositivo;
                OFS_RELOAD: reload_d = salidaDispositivo;
                OFS_MASK:   mask_d   = salidaDispositivo[2:0];
                OFS_ACK: begin
                    if (salidaDispositivo[IRQ_TIMER]) pend_tmr_d = 1'b0;
                    if (salidaDispositivo[IRQ_OVF])   pend_ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (fire)     pend_tmr_d = 1'b1;
        if (overflow) pend_ovf_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= 8'h00;
            reload_q   <= 8'h00;
            mask_q     <= 3'b000;
            counter_q  <= 8'h00;
            presc_q    <= '0;
            pend_tmr_q <= 1'b0;
            pend_ovf_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            reload_q   <= reload_d;
            mask_q     <= mask_d;
            counter_q  <= counter_d;
            presc_q    <= presc_d;
            pend_tmr_q <= pend_tmr_d;
            pend_ovf_q <= pend_ovf_d;
        end
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: directed scenarios plus random bus/input traffic against a behavioural model.
// Model tracks FIFO as a queue and the timer as elapsed cycles since the last reload write.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_io_bus_responder;

    localparam int D = 4;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, rd, wr;
    logic [15:0] dir;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [2:0]  irq;
    logic [7:0]  port;
    logic [7:0]  dext;
    logic        dvalid;
    logic        dready;

    always #5 clk = ~clk;

    io_bus_responder #(.BASE_ADDR(16'hFF00), .FIFO_DEPTH(D), .PRESCALE(P)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable_whisbone    (en),
        .rd                 (rd),
        .wr                 (wr),
        .dir                (dir),
        .salidaDispositivo  (wdata),
        .entradaDispositivo (rdata),
        .interrupciones     (irq),
        .puerto_salida      (port),
        .dato_ext           (dext),
        .dato_ext_valid     (dvalid),
        .dato_ext_ready     (dready)
    );

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_out, m_reload;
    logic [2:0] m_mask;
    logic       m_p0, m_p2;
    int         m_t;

    int checks = 0;
    int passed = 0;

    logic [7:0] last_rd, last_port;
    logic [2:0] last_irq;
    logic       last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] off);
        int n;
        n = m_q.size();
        case (off)
            4'd0: return m_out;
            4'd1: return (n > 0) ? m_q[0] : 8'h00;
            4'd2: return {m_p2, (n > 0), m_p0, (n == D), (n == 0), 3'((n > 7) ? 7 : n)};
            4'd3: return m_reload;
            4'd4: return {5'b0, m_mask};
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_clear();
        m_q.delete();
        m_out = 0; m_reload = 0; m_mask = 0; m_p0 = 0; m_p2 = 0; m_t = 0;
    endtask

    // One bus cycle: compare outputs mid-cycle, then advance the model at the rising edge
    task automatic step();
        logic       sel, rd_e, wr_e, pop, full, push, ovf, expire;
        logic [3:0] off;
        logic [7:0] exp_rd;
        logic [2:0] exp_irq;
        @(negedge clk);
        sel  = en & (dir[15:4] == 12'hFF0);
        off  = dir[3:0];
        rd_e = sel & rd & ~wr;
        wr_e = sel & wr;
        last_rd = rdata; last_port = port; last_irq = irq; last_ready = dready;
        if (reset) begin
            check("rst_rdata", rdata, 0);
            check("rst_ready", dready, 0);
            check("rst_irq", irq, 0);
            check("rst_port", port, 0);
        end else begin
            exp_rd  = rd_e ? m_read(off) : 8'h00;
            exp_irq = {m_p2, (m_q.size() > 0), m_p0} & m_mask;
            check("rdata", rdata, exp_rd);
            check("ready", dready, (m_q.size() < D));
            check("irq", irq, exp_irq);
            check("port", port, m_out);
        end
        @(posedge clk);
        if (reset) begin
            m_clear();
        end else begin
            full = (m_q.size() == D);
            pop  = rd_e && (off == 4'd1) && (m_q.size() > 0);
            push = dvalid && (!full || pop);
            ovf  = dvalid && full && !pop;
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(dext);
            expire = 1'b0;
            if (m_reload != 0) begin
                expire = (((m_t + 1) % (int'(m_reload) * P)) == 0);
                m_t++;
            end
            if (wr_e && off == 4'd5) begin
                if (wdata[0]) m_p0 = 1'b0;
                if (wdata[2]) m_p2 = 1'b0;
            end
            if (expire) m_p0 = 1'b1;
            if (ovf)    m_p2 = 1'b1;
            if (wr_e && off == 4'd0) m_out = wdata;
            if (wr_e && off == 4'd4) m_mask = wdata[2:0];
            if (wr_e && off == 4'd3) begin
                m_reload = wdata;
                m_t = 0;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        en = 0; rd = 0; wr = 0; dir = 16'h0000; wdata = 8'h00; dvalid = 0; dext = 8'h00;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        set_idle(); en = 1; wr = 1; dir = a; wdata = d;
        step(); set_idle();
    endtask

    task automatic bus_rd(input logic [15:0] a);
        set_idle(); en = 1; rd = 1; dir = a;
        step(); set_idle();
    endtask

    task automatic push(input logic [7:0] d);
        set_idle(); dvalid = 1; dext = d;
        step(); set_idle();
    endtask

    initial begin
        int rise;
        logic [7:0] pops [4];
        pops[0] = 8'h22; pops[1] = 8'h33; pops[2] = 8'h44; pops[3] = 8'h66;
        m_clear();
        set_idle();
        reset = 1;
        step(); step();
        reset = 0;
        step();
        check("ready_after_rst", last_ready, 1);
        bus_rd(16'hFF02);
        check("status_after_rst", last_rd, 8'h08);

        // Output port: in-window write lands, out-of-window write ignored
        bus_wr(16'hFF00, 8'hA5);
        step();
        check("port_a5", last_port, 8'hA5);
        bus_wr(16'hFE00, 8'h5A);
        step();
        check("port_outside", last_port, 8'hA5);

        // Fill, overflow, acknowledge
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        step();
        check("ready_full", last_ready, 0);
        bus_rd(16'hFF02);
        check("status_full", last_rd, 8'h54);
        push(8'h55);
        bus_rd(16'hFF02);
        check("status_ovf", last_rd, 8'hD4);
        bus_wr(16'hFF05, 8'h04);

        // Push and pop together while full
        set_idle(); dvalid = 1; dext = 8'h66; en = 1; rd = 1; dir = 16'hFF01;
        step(); set_idle();
        check("pushpop_rd", last_rd, 8'h11);
        bus_rd(16'hFF02);
        check("status_pushpop", last_rd, 8'h54);
        for (int i = 0; i < 4; i++) begin
            bus_rd(16'hFF01);
            check("pop_order", last_rd, pops[i]);
        end
        bus_rd(16'hFF01);
        check("pop_empty", last_rd, 8'h00);

        // Timer period, acknowledge, acknowledge colliding with expiry
        bus_wr(16'hFF04, 8'h01);
        bus_wr(16'hFF03, 8'h03);
        rise = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (last_irq[0]) begin
                rise = k - 1;
                break;
            end
        end
        check("timer_rise", rise, 12);
        bus_wr(16'hFF05, 8'h01);
        step();
        check("ack_clear", last_irq[0], 0);
        for (int k = 0; k < 8; k++) step();
        bus_wr(16'hFF05, 8'h01);
        step();
        check("ack_vs_expiry", last_irq[0], 1);

        // Reset in the middle of timer activity with two queued bytes
        push(8'h77); push(8'h88);
        reset = 1;
        step();
        reset = 0;
        bus_rd(16'hFF02);
        check("status_post_rst", last_rd, 8'h08);
        for (int k = 0; k < 30; k++) step();
        check("irq_post_rst", last_irq, 0);

        // Random traffic against the model
        bus_wr(16'hFF04, 8'h07);
        for (int n = 0; n < 1500; n++) begin
            set_idle();
            reset  = ($urandom_range(0, 199) == 0);
            en     = ($urandom_range(0, 3) != 0);
            rd     = $urandom_range(0, 1);
            wr     = ($urandom_range(0, 3) == 0);
            dir    = {(($urandom_range(0, 4) != 0) ? 12'hFF0 : 12'(($urandom_range(0, 15) << 4) | 12'hE01)),
                      4'($urandom_range(0, 7))};
            wdata  = 8'($urandom);
            if (dir[3:0] == 4'd3) wdata = 8'($urandom_range(0, 3));
            dvalid = $urandom_range(0, 1);
            dext   = 8'($urandom);
            step();
        end
        reset = 0;
        set_idle();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
